// File: rtl/bus_arb_pkg.sv
// Shared encodings and defaults for the two-master memory bus arbiter.
package bus_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Master identifiers, also used as the grant/last register values.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Read data handed back to a master whose transfer was ended by the watchdog.
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select. Pure combinational; the caller registers the result.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // A lone requester always wins; on contention the master that was not served last wins.
  always_comb begin
    winner = M0;
    case (req)
      2'b01:   winner = M0;
      2'b10:   winner = M1;
      2'b11:   winner = ~last;
      default: winner = M0;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one picorv32-native memory bus between two masters with round-robin
// arbitration, grant held for the whole transfer, and a per-transfer watchdog
// that completes stalled transfers with an error word.
module mem_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        busy,
  output logic        timeout_err,
  output logic        err_master,
  input  logic        err_clear
);

  // Counter just wide enough to reach TIMEOUT_CYCLES-1; it saturates instead of wrapping.
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nx;
  logic            grant, grant_nx;
  logic            last, last_nx;
  logic [WD_W-1:0] wd_cnt, wd_nx;
  logic            timeout_err_nx;
  logic            err_master_nx;
  logic            winner;
  logic            g_valid;
  logic            done;
  logic [31:0]     done_data;

  rr_pick2 u_pick (
    .req    ({m1_valid, m0_valid}),
    .last   (last),
    .winner (winner)
  );

  // Next-state, bus mux and completion decode; everything defaults to the idle/zero view.
  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    last_nx        = last;
    wd_nx          = wd_cnt;
    err_master_nx  = err_master;
    timeout_err_nx = timeout_err & ~err_clear;
    g_valid        = 1'b0;
    done           = 1'b0;
    done_data      = 32'h0;
    s_valid        = 1'b0;
    s_instr        = 1'b0;
    s_addr         = 32'h0;
    s_wdata        = 32'h0;
    s_wstrb        = 4'h0;

    case (state)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          state_nx = ST_BUSY;
          grant_nx = winner;
          wd_nx    = '0;
        end
      end

      ST_BUSY: begin
        g_valid = (grant == M1) ? m1_valid : m0_valid;
        s_valid = g_valid;
        s_instr = (grant == M1) ? m1_instr : m0_instr;
        s_addr  = (grant == M1) ? m1_addr  : m0_addr;
        s_wdata = (grant == M1) ? m1_wdata : m0_wdata;
        s_wstrb = (grant == M1) ? m1_wstrb : m0_wstrb;

        if (!g_valid) begin
          // Master withdrew its request: abandon silently, fairness history untouched.
          state_nx = ST_IDLE;
        end else if (s_ready) begin
          // Slave completion wins even on the watchdog's final cycle.
          done      = 1'b1;
          done_data = s_rdata;
          last_nx   = grant;
          state_nx  = ST_IDLE;
        end else if (wd_cnt == WD_LAST) begin
          // Watchdog expiry: retract the slave request and answer the master ourselves.
          s_valid        = 1'b0;
          done           = 1'b1;
          done_data      = ERR_DATA;
          timeout_err_nx = 1'b1;
          err_master_nx  = grant;
          last_nx        = grant;
          state_nx       = ST_IDLE;
        end else if (wd_cnt != '1) begin
          wd_nx = wd_cnt + 1'b1;
        end
      end

      default: state_nx = ST_IDLE;
    endcase

    m0_ready = done && (grant == M0);
    m1_ready = done && (grant == M1);
    m0_rdata = m0_ready ? done_data : 32'h0;
    m1_rdata = m1_ready ? done_data : 32'h0;
    busy     = (state == ST_BUSY);
  end

  // Control registers; an asynchronous reset drops the bus back to idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= M0;
      last        <= M1;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      err_master  <= M0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last        <= last_nx;
      wd_cnt      <= wd_nx;
      timeout_err <= timeout_err_nx;
      err_master  <= err_master_nx;
    end
  end

endmodule
